multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum consecutive memory-wait cycles before fault.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 7: instruction register bits [6:0].
REQ-005 SHALL have port funct3, input, 3: instruction register bits [14:12].
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-008 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, branch_taken, fault, each 1 bit.
REQ-009 SHALL have output alu_src, 1: 0 selects the register operand, 1 selects the immediate operand of the ALU source mux.
REQ-010 SHALL have output alu_op, 2: 00 add, 01 subtract, 10 R-type (funct decoded downstream), 11 I-type.
REQ-011 SHALL have output state, 3: current FSM state encoding.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=7; codes 5 and 6 SHALL go to FAULT on the next edge.
REQ-013 All outputs SHALL be combinational from state, opcode, funct3, zero and mem_ready; outputs not listed for a state SHALL be 0.
REQ-014 FETCH: mem_read=1; when mem_ready=1, ir_write=1 and pc_write=1 in that same cycle, and next state SHALL be DECODE; otherwise stay in FETCH.
REQ-015 DECODE: one cycle, no strobes asserted; next state SHALL be EXECUTE for the legal opcodes 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), otherwise FAULT.
REQ-016 Branches SHALL be legal only for funct3 000 (beq) or 001 (bne); any other funct3 SHALL go to FAULT from DECODE.
REQ-017 EXECUTE: alu_src=0 for R and BRANCH, 1 for I, LOAD and STORE; alu_op=10 for R, 11 for I, 00 for LOAD/STORE, 01 for BRANCH.
REQ-018 EXECUTE next state SHALL be WB for R/I, MEM for LOAD/STORE, and FETCH for BRANCH.
REQ-019 EXECUTE for BRANCH: branch_taken = zero XOR funct3[0]; pc_write = branch_taken.
REQ-020 MEM: mem_read=1 for LOAD, mem_write=1 for STORE, alu_src=1, alu_op=00, held until mem_ready=1; then LOAD goes to WB and STORE goes to FETCH.
REQ-021 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LOAD, 0 for R/I; next state SHALL be FETCH.
REQ-022 A wait counter of width clog2(MAX_WAIT+1) SHALL count cycles in FETCH or MEM with mem_ready=0; it SHALL clear on any state change and on mem_ready=1.
REQ-023 If the counter equals MAX_WAIT and mem_ready=0, next state SHALL be FAULT; mem_ready=1 in that same cycle SHALL take priority and complete normally.
REQ-024 FAULT SHALL be sticky until reset, with fault=1 and all other strobes 0.
REQ-025 opcode and funct3 SHALL be treated as stable from DECODE through WB; the block SHALL NOT latch them.

Reset
REQ-026 Asserting reset SHALL immediately force state=FETCH and the wait counter to 0, and clear fault, independent of clk and including mid-instruction.
REQ-027 While reset=1 all strobes SHALL be 0, including mem_read; after release, FETCH behaviour SHALL resume on the first edge.

Verification
REQ-028 R-type add: opcode 0110011, mem_ready=1 in FETCH -> states 0,1,2,4,0; alu_src=0 and alu_op=10 in EXECUTE; reg_write=1 only in WB.
REQ-029 LOAD with 2 wait cycles in MEM: opcode 0000011 -> alu_src=1, alu_op=00; mem_read held 3 cycles in MEM; WB has mem_to_reg=1.
REQ-030 Branches: beq with zero=1 gives branch_taken=1 and pc_write=1 in EXECUTE; bne with zero=1 gives branch_taken=0 and pc_write=0; both return to FETCH.
REQ-031 Illegal opcode 1111111 at DECODE -> state 7 and fault=1 on the next edge, and it remains there for 20 cycles with any inputs.
REQ-032 Timeout: mem_ready held 0 in FETCH with MAX_WAIT=15 -> FAULT after 16 FETCH cycles; in a separate run, mem_ready=1 on the 16th cycle completes the fetch normally.
REQ-033 Asynchronous reset pulse between clock edges during MEM of a STORE -> state=0 and mem_write=0 immediately; a normal fetch follows after reset is released.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle datapath and its sequencing FSM.
// The datapath (master) supplies instruction fields and status; the controller (slave) returns strobes.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch_taken;
    logic       fault;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] state;

    modport master (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
               branch_taken, fault, alu_src, alu_op, state
    );

    modport slave (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
               branch_taken, fault, alu_src, alu_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a memory-wait watchdog
// and a sticky FAULT state. All strobes are combinational from state and the live instruction fields.
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.slave bus
);

    localparam int unsigned            WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        FAULT   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic is_r, is_i, is_load, is_store, is_branch, branch_ok;

    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic       mem_to_reg, branch_taken, fault, alu_src;
    logic [1:0] alu_op;

    assign is_r      = (bus.opcode == OP_R);
    assign is_i      = (bus.opcode == OP_I);
    assign is_load   = (bus.opcode == OP_LOAD);
    assign is_store  = (bus.opcode == OP_STORE);
    assign is_branch = (bus.opcode == OP_BRANCH);
    assign branch_ok = is_branch && (bus.funct3[2:1] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        branch_taken = 1'b0;
        fault        = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                if (is_r || is_i || is_load || is_store || branch_ok) state_d = EXECUTE;
                else                                                  state_d = FAULT;
            end
            EXECUTE: begin
                if (is_r) begin
                    alu_op  = 2'b10;
                    state_d = WB;
                end else if (is_i) begin
                    alu_src = 1'b1;
                    alu_op  = 2'b11;
                    state_d = WB;
                end else if (is_load || is_store) begin
                    alu_src = 1'b1;
                    state_d = MEM;
                end else if (is_branch) begin
                    alu_op       = 2'b01;
                    branch_taken = bus.zero ^ bus.funct3[0];
                    pc_write     = bus.zero ^ bus.funct3[0];
                    state_d      = FETCH;
                end else begin
                    state_d = FAULT;
                end
            end
            MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.mem_ready)                state_d = is_load ? WB : FETCH;
                else if (wait_q == WAIT_LIMIT)    state_d = FAULT;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                state_d    = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // Watchdog only advances while parked in a memory phase; any progress clears it.
    always_comb begin
        if (state_d != state_q || bus.mem_ready)       wait_d = '0;
        else if (state_q == FETCH || state_q == MEM)   wait_d = wait_q + WAIT_W'(1);
        else                                           wait_d = '0;
    end

    // Reset masks the strobes combinationally so FETCH's mem_read cannot leak while held.
    assign bus.pc_write     = pc_write     & ~reset;
    assign bus.ir_write     = ir_write     & ~reset;
    assign bus.reg_write    = reg_write    & ~reset;
    assign bus.mem_read     = mem_read     & ~reset;
    assign bus.mem_write    = mem_write    & ~reset;
    assign bus.mem_to_reg   = mem_to_reg   & ~reset;
    assign bus.branch_taken = branch_taken & ~reset;
    assign bus.fault        = fault        & ~reset;
    assign bus.alu_src      = alu_src      & ~reset;
    assign bus.alu_op       = reset ? 2'b00 : alu_op;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences plus randomized traffic,
// each cycle's expected outputs come from an instruction-level reference model.
module tb_multicycle_control;

    localparam int unsigned MAX_WAIT = 15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BAD = 5;

    typedef struct {
        logic [13:0] vec;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    multicycle_control_if bus ();

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    event sample_ev;
    int   n_tests  = 0;
    int   n_failed = 0;

    int m_state = 0;
    int m_wait  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            OP_R:      return K_R;
            OP_I:      return K_I;
            OP_LOAD:   return K_LD;
            OP_STORE:  return K_ST;
            OP_BRANCH: return K_BR;
            default:   return K_BAD;
        endcase
    endfunction

    // {state, alu_op, alu_src, pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, branch_taken, fault}
    function automatic logic [13:0] model_out(input logic [6:0] op, input logic [2:0] f3,
                                              input logic z, input logic mr);
        int k;
        logic [2:0] st;
        logic [1:0] aop;
        logic asrc, pcw, irw, rw, mrd, mw, m2r, bt, flt;
        k = kind_of(op);
        st = 3'(m_state);
        aop = 2'b00;
        {asrc, pcw, irw, rw, mrd, mw, m2r, bt, flt} = '0;
        case (m_state)
            0: begin mrd = 1'b1; irw = mr; pcw = mr; end
            2: begin
                if (k == K_R) aop = 2'b10;
                else if (k == K_I) begin asrc = 1'b1; aop = 2'b11; end
                else if (k == K_LD || k == K_ST) asrc = 1'b1;
                else if (k == K_BR) begin aop = 2'b01; bt = z ^ f3[0]; pcw = z ^ f3[0]; end
            end
            3: begin asrc = 1'b1; mrd = (k == K_LD); mw = (k == K_ST); end
            4: begin rw = 1'b1; m2r = (k == K_LD); end
            7: flt = 1'b1;
            default: ;
        endcase
        return {st, aop, asrc, pcw, irw, rw, mrd, mw, m2r, bt, flt};
    endfunction

    // Advance the instruction-level model by one clock.
    task automatic model_next(input logic [6:0] op, input logic [2:0] f3, input logic mr);
        int k;
        int nxt;
        bit stall;
        k = kind_of(op);
        nxt = 7;
        case (m_state)
            0: nxt = mr ? 1 : 0;
            1: nxt = (k <= K_ST || (k == K_BR && f3 <= 3'd1)) ? 2 : 7;
            2: nxt = (k <= K_I) ? 4 : (k <= K_ST) ? 3 : (k == K_BR) ? 0 : 7;
            3: nxt = mr ? ((k == K_LD) ? 4 : 0) : 3;
            4: nxt = 0;
            default: nxt = 7;
        endcase
        stall = (m_state == 0 || m_state == 3) && !mr;
        if (stall) begin
            m_wait = m_wait + 1;
            if (m_wait > int'(MAX_WAIT)) nxt = 7;
        end
        if (!stall || nxt != m_state) m_wait = 0;
        m_state = nxt;
    endtask

    task automatic push_exp(input logic [13:0] v, input string tag);
        exp_t e;
        e.vec = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic z,
                        input logic mr, input string tag);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.zero = z;
        bus.mem_ready = mr;
        push_exp(model_out(op, f3, z, mr), tag);
        #1 -> sample_ev;
        model_next(op, f3, mr);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        bus.opcode = 7'($urandom);
        bus.funct3 = 3'($urandom);
        bus.zero = 1'($urandom);
        bus.mem_ready = 1'($urandom);
        reset = 1'b1;
        m_state = 0;
        m_wait = 0;
        push_exp(14'd0, tag);
        #1 -> sample_ev;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic [13:0] act;
        forever begin
            @(sample_ev);
            act = {bus.state, bus.alu_op, bus.alu_src, bus.pc_write, bus.ir_write, bus.reg_write,
                   bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.branch_taken, bus.fault};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_failed++;
                $display("FAIL scoreboard_empty: got %b with no expectation queued", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e.vec) begin
                    n_failed++;
                    $display("FAIL %s: got %b required %b (st,aop,src,pcw,irw,rw,mr,mw,m2r,bt,flt)",
                             e.tag, act, e.vec);
                end
            end
        end
    end

    initial begin : driver
        logic [6:0] op;
        logic [2:0] f3;
        int r;
        reset = 1'b1;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset("reset_state");

        step(OP_R, 3'd0, 1'b0, 1'b1, "r_fetch");
        step(OP_R, 3'd0, 1'b0, 1'b0, "r_decode");
        step(OP_R, 3'd0, 1'b1, 1'b0, "r_execute");
        step(OP_R, 3'd0, 1'b0, 1'b0, "r_wb");

        step(OP_LOAD, 3'd2, 1'b0, 1'b1, "ld_fetch");
        step(OP_LOAD, 3'd2, 1'b0, 1'b0, "ld_decode");
        step(OP_LOAD, 3'd2, 1'b0, 1'b0, "ld_execute");
        step(OP_LOAD, 3'd2, 1'b0, 1'b0, "ld_mem_wait1");
        step(OP_LOAD, 3'd2, 1'b0, 1'b0, "ld_mem_wait2");
        step(OP_LOAD, 3'd2, 1'b0, 1'b1, "ld_mem_done");
        step(OP_LOAD, 3'd2, 1'b0, 1'b0, "ld_wb");

        step(OP_BRANCH, 3'd0, 1'b1, 1'b1, "beq_fetch");
        step(OP_BRANCH, 3'd0, 1'b1, 1'b0, "beq_decode");
        step(OP_BRANCH, 3'd0, 1'b1, 1'b0, "beq_taken");
        step(OP_BRANCH, 3'd1, 1'b1, 1'b1, "bne_fetch");
        step(OP_BRANCH, 3'd1, 1'b1, 1'b0, "bne_decode");
        step(OP_BRANCH, 3'd1, 1'b1, 1'b0, "bne_not_taken");

        step(OP_I, 3'd0, 1'b0, 1'b1, "i_fetch");
        step(OP_I, 3'd0, 1'b0, 1'b1, "i_decode");
        step(OP_I, 3'd0, 1'b0, 1'b1, "i_execute");
        step(OP_I, 3'd0, 1'b0, 1'b1, "i_wb");

        step(OP_STORE, 3'd2, 1'b0, 1'b1, "st_fetch");
        step(OP_STORE, 3'd2, 1'b0, 1'b1, "st_decode");
        step(OP_STORE, 3'd2, 1'b0, 1'b0, "st_execute");
        step(OP_STORE, 3'd2, 1'b0, 1'b1, "st_mem_done");

        step(OP_BAD, 3'd0, 1'b0, 1'b1, "bad_fetch");
        step(OP_BAD, 3'd0, 1'b0, 1'b0, "bad_decode");
        for (int i = 0; i < 20; i++)
            step(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), "fault_sticky");
        do_reset("reset_from_fault");

        step(OP_BRANCH, 3'd2, 1'b0, 1'b1, "bad_funct3_fetch");
        step(OP_BRANCH, 3'd2, 1'b0, 1'b0, "bad_funct3_decode");
        step(OP_BRANCH, 3'd2, 1'b0, 1'b0, "bad_funct3_fault");
        do_reset("reset_after_bad_funct3");

        for (int i = 0; i < 16; i++) step(OP_R, 3'd0, 1'b0, 1'b0, "timeout_stall");
        step(OP_R, 3'd0, 1'b0, 1'b1, "timeout_fault");
        do_reset("reset_after_timeout");

        for (int i = 0; i < 15; i++) step(OP_R, 3'd0, 1'b0, 1'b0, "edge_stall");
        step(OP_R, 3'd0, 1'b0, 1'b1, "edge_ready_16th");
        step(OP_R, 3'd0, 1'b0, 1'b0, "edge_decode");

        do_reset("reset_pre_store");
        step(OP_STORE, 3'd2, 1'b0, 1'b1, "ast_fetch");
        step(OP_STORE, 3'd2, 1'b0, 1'b0, "ast_decode");
        step(OP_STORE, 3'd2, 1'b0, 1'b0, "ast_execute");
        bus.mem_ready = 1'b0;
        push_exp(model_out(OP_STORE, 3'd2, 1'b0, 1'b0), "ast_mem");
        #1 -> sample_ev;
        #1 reset = 1'b1;
        m_state = 0;
        m_wait = 0;
        push_exp(14'd0, "async_reset_mid_mem");
        #1 -> sample_ev;
        @(negedge clk);
        reset = 1'b0;
        step(OP_R, 3'd0, 1'b0, 1'b1, "post_reset_fetch");
        step(OP_R, 3'd0, 1'b0, 1'b0, "post_reset_decode");

        op = OP_R;
        f3 = '0;
        for (int c = 0; c < 2500; c++) begin
            if (m_state == 7 && $urandom_range(0, 3) == 0) begin
                do_reset("rand_reset");
            end else begin
                if (m_state == 0) begin
                    r = int'($urandom_range(0, 9));
                    case (r)
                        0, 1:    op = OP_R;
                        2, 3:    op = OP_I;
                        4, 5:    op = OP_LOAD;
                        6:       op = OP_STORE;
                        7, 8:    op = OP_BRANCH;
                        default: op = 7'($urandom);
                    endcase
                    if (op == OP_BRANCH && $urandom_range(0, 9) != 0) f3 = 3'($urandom_range(0, 1));
                    else                                              f3 = 3'($urandom);
                end
                step(op, f3, 1'($urandom), ($urandom_range(0, 99) < 55), "random");
            end
        end

        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
